serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder walks a+b+cin LSB-first over WIDTH cycles.
// Result appears WIDTH+1 edges after start (accept edge counted); start is ignored while busy, accepted in DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shifted;

    assign fa_s        = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_c        = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    assign res_shifted = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            SHIFT: begin
                res_d   = res_shifted;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // The last bit lands in the result and the outputs on the same edge.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = res_shifted;
                    cout_d  = fa_c;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int n_total = 0;
    int n_pass  = 0;

    // Model of what the held result outputs should currently show.
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, cout, sum});
    endfunction

    function automatic logic [31:0] want(input logic bz, input logic dn);
        return 32'({bz, dn, exp_cout, exp_sum});
    endfunction

    // One addition. hold keeps start high while busy; poke_at/rst_at (1..W, 0 = off)
    // raise start or rst during that busy cycle. Returns in the DONE cycle (or after reset).
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input bit hold, input int poke_at, input int rst_at);
        logic [W:0] ref_sum;
        ref_sum = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        step();
        for (int i = 1; i <= W; i++) begin
            start = hold;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            check({tag, " busy"}, outs(), want(1'b1, 1'b0));
            if (i == poke_at) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                step();
                rst = 1'b0;
                exp_sum = '0; exp_cout = 1'b0;
                check({tag, " reset"}, outs(), want(1'b0, 1'b0));
                return;
            end
            step();
        end
        start = 1'b0;
        {exp_cout, exp_sum} = ref_sum;
        check({tag, " done"}, outs(), want(1'b0, 1'b1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = 8'h5A; b = 8'hA5; cin = 1'b1;
        step();
        step();
        check("reset state", outs(), 32'd0);
        rst = 1'b0; start = 1'b0;
        step();
        check("idle", outs(), 32'd0);

        do_op("basic 05+03", 8'h05, 8'h03, 1'b0, 1'b0, 0, 0);
        check("basic sum", 32'(sum), 32'h08);
        step();
        check("basic after", outs(), want(1'b0, 1'b0));

        do_op("carry FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        check("carry1 value", 32'({cout, sum}), 32'h100);
        do_op("carry FF+FF+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
        check("carry2 value", 32'({cout, sum}), 32'h1FF);
        step();

        do_op("busy start", 8'h10, 8'h20, 1'b0, 1'b0, 3, 0);
        check("busy start sum", 32'(sum), 32'h30);
        for (int i = 0; i < 12; i++) begin
            step();
            check("no second done", outs(), want(1'b0, 1'b0));
        end

        do_op("b2b 01+01", 8'h01, 8'h01, 1'b0, 1'b1, 0, 0);
        check("b2b1 value", 32'({cout, sum}), 32'h002);
        do_op("b2b 80+80", 8'h80, 8'h80, 1'b0, 1'b0, 0, 0);
        check("b2b2 value", 32'({cout, sum}), 32'h100);
        step();

        do_op("pre-reset 33+44", 8'h33, 8'h44, 1'b0, 1'b0, 0, 0);
        step();
        do_op("reset mid-op", 8'h77, 8'h99, 1'b1, 1'b0, 0, 4);
        check("reset clears", 32'({busy, done, cout, sum}), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("no done after reset", outs(), want(1'b0, 1'b0));
        end

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        step();
        check("reset overrides start", outs(), 32'd0);
        rst = 1'b0;
        do_op("fresh after reset", 8'h12, 8'h34, 1'b1, 1'b0, 0, 0);
        check("fresh value", 32'(sum), 32'h47);

        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                step();
                check("rand idle", outs(), want(1'b0, 1'b0));
            end
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, 0);
        end
        step();
        check("final idle", outs(), want(1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
